sfx_voice_player: RTL and testbench

- Upstream feeder for the audio codec interface.
- Turns per-player trigger inputs into timed sample-ROM address sequences at ~44.1 kHz, one voice per player.
- Mixes the active voices with gain and saturation, then hands each mixed sample to the codec write port through a ready/valid handshake.
- Replaces ad-hoc play counters with explicit per-voice state machines and a proper sample strobe.

---
 rtl/sfx_voice_player.sv | 149 ++++++++++++++
 tb/tb_sfx_voice_player.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_voice_player.sv
// Per-voice sample-ROM address sequencer with a sample-rate divider, gain/saturating mixer
// and a ready/valid style write port towards the audio codec.
module sfx_voice_player #(
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned SAMPLE_LEN = 32767,
  parameter int unsigned DIV        = 1134,
  parameter int unsigned GAIN_SHIFT = 2
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [NUM_VOICES-1:0]        trig,
  output logic [NUM_VOICES*ADDR_W-1:0] rom_addr,
  input  logic [NUM_VOICES*24-1:0]     rom_q,
  input  logic                         write_ready,
  output logic                         write,
  output logic [23:0]                  writedata_left,
  output logic [23:0]                  writedata_right,
  output logic [NUM_VOICES-1:0]        busy,
  output logic                         overrun
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SUM_W = 24 + $clog2(NUM_VOICES) + GAIN_SHIFT;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SAMPLE_LEN - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = $signed({{(SUM_W-23){1'b0}}, {23{1'b1}}});
  localparam logic signed [SUM_W-1:0] SAT_MIN = $signed({{(SUM_W-23){1'b1}}, {23{1'b0}}});

  typedef enum logic {S_IDLE, S_PLAY} voice_state_e;

  logic [DIV_W-1:0]      div_q;
  logic                  tick_c;
  logic [NUM_VOICES-1:0] trig_q;
  logic [NUM_VOICES-1:0] rise_c;
  voice_state_e          state_q [NUM_VOICES];
  logic [ADDR_W-1:0]     addr_q  [NUM_VOICES];
  logic                  tick1_q, tick2_q;
  logic [NUM_VOICES-1:0] busy1_q;
  logic signed [SUM_W-1:0] sum_c, shifted_c;
  logic [23:0]           sat_c;
  logic [23:0]           wd_q;
  logic                  pending_q;
  logic                  overrun_q;

  // Sample-rate divider: tick on the last count, then wrap
  assign tick_c = (div_q == DIV_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset)       div_q <= '0;
    else if (tick_c) div_q <= '0;
    else             div_q <= div_q + DIV_W'(1);
  end

  assign rise_c = trig & ~trig_q;

  // Voice state machines; a trigger rise has priority over a same-cycle tick
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      trig_q <= '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        state_q[i] <= S_IDLE;
        addr_q[i]  <= '0;
      end
    end else begin
      trig_q <= trig;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        case (state_q[i])
          S_IDLE: begin
            addr_q[i] <= '0;
            if (rise_c[i]) state_q[i] <= S_PLAY;
          end
          S_PLAY: begin
            if (rise_c[i]) begin
              addr_q[i] <= '0;
            end else if (tick_c) begin
              if (addr_q[i] == ADDR_LAST) begin
                state_q[i] <= S_IDLE;
                addr_q[i]  <= '0;
              end else begin
                addr_q[i] <= addr_q[i] + ADDR_W'(1);
              end
            end
          end
          default: begin
            state_q[i] <= S_IDLE;
            addr_q[i]  <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    rom_addr = '0;
    busy     = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      rom_addr[i*ADDR_W +: ADDR_W] = addr_q[i];
      busy[i]                      = (state_q[i] == S_PLAY);
    end
  end

  // Pipeline alignment: ROM registers addresses at T+1, data valid at T+2
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick1_q <= 1'b0;
      tick2_q <= 1'b0;
      busy1_q <= '0;
    end else begin
      tick1_q <= tick_c;
      tick2_q <= tick1_q;
      busy1_q <= busy;
    end
  end

  // Mix voices that were busy when their address was sampled, apply gain, saturate
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (busy1_q[i]) sum_c = sum_c + SUM_W'($signed(rom_q[i*24 +: 24]));
    end
    shifted_c = sum_c <<< GAIN_SHIFT;
    if (shifted_c > SAT_MAX)      sat_c = SAT_MAX[23:0];
    else if (shifted_c < SAT_MIN) sat_c = SAT_MIN[23:0];
    else                          sat_c = shifted_c[23:0];
  end

  // Codec handshake: the strobe follows the pending flag directly, suppressed during reset
  assign write = pending_q & write_ready & ~reset;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wd_q      <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (tick2_q) begin
      wd_q      <= sat_c;
      pending_q <= 1'b1;
      if (pending_q && !write_ready) overrun_q <= 1'b1;
    end else if (write) begin
      pending_q <= 1'b0;
    end
  end

  assign writedata_left  = wd_q;
  assign writedata_right = wd_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_sfx_voice_player.sv
// Directed bench for sfx_voice_player; timing is scaled down (short divider and sample length).
module tb_sfx_voice_player;

  localparam int DIV  = 20;
  localparam int SLEN = 600;

  logic        clk;
  logic        reset;
  logic [1:0]  trig;
  logic [29:0] rom_addr;
  logic [47:0] rom_q;
  logic        write_ready;
  logic        write;
  logic [23:0] wdl, wdr;
  logic [1:0]  busy;
  logic        overrun;

  logic        rom_mode;
  logic [23:0] rom_c0, rom_c1;

  int checks = 0;
  int errors = 0;

  sfx_voice_player #(
    .NUM_VOICES(2), .ADDR_W(15), .SAMPLE_LEN(SLEN), .DIV(DIV), .GAIN_SHIFT(2)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .trig(trig), .rom_addr(rom_addr), .rom_q(rom_q),
    .write_ready(write_ready), .write(write), .writedata_left(wdl), .writedata_right(wdr),
    .busy(busy), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered sample ROM: q = address, or a per-voice constant
  always_ff @(posedge clk) begin
    rom_q[23:0]  <= rom_mode ? rom_c0 : {9'd0, rom_addr[14:0]};
    rom_q[47:24] <= rom_mode ? rom_c1 : {9'd0, rom_addr[29:15]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_write(input int max_cyc, output int n, output bit got);
    n = 0;
    got = 1'b0;
    while (n < max_cyc && !got) begin
      step();
      n++;
      if (write === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; trig = 2'b00; write_ready = 1'b1; rom_mode = 1'b0;
    rom_c0 = '0; rom_c1 = '0;
    repeat (3) step();
    checks++;
    if ({write, busy, overrun, rom_addr, wdl, wdr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got w=%b busy=%b ovr=%b addr=%h wd=%h/%h required all zero",
               write, busy, overrun, rom_addr, wdl, wdr);
    end
    reset = 1'b0;
  endtask

  task automatic test_silence();
    int n; bit got;
    wait_write(200, n, got);
    checks++;
    if (!got || n != DIV + 2) begin
      errors++; $display("FAIL first_write_latency: got %0d (seen=%0d) required %0d", n, got, DIV + 2);
    end
    for (int k = 0; k < 3; k++) begin
      wait_write(200, n, got);
      checks++;
      if (!got || n != DIV || wdl !== 24'd0 || wdr !== 24'd0 || busy !== 2'b00 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL silence_period: got n=%0d wd=%h/%h busy=%b ovr=%b required n=%0d wd=0 busy=0 ovr=0",
                 n, wdl, wdr, busy, overrun, DIV);
      end
    end
  endtask

  task automatic test_voice_advance();
    int n; bit got;
    trig = 2'b01;
    step();
    trig = 2'b00;
    checks++;
    if (busy !== 2'b01 || rom_addr[14:0] !== 15'd0) begin
      errors++; $display("FAIL trig_start: got busy=%b addr0=%0d required busy=01 addr0=0", busy, rom_addr[14:0]);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_write(2 * DIV + 5, n, got);
      checks++;
      if (!got || wdl !== 24'(k * 4) || wdr !== 24'(k * 4) || rom_addr[14:0] !== 15'(k)) begin
        errors++;
        $display("FAIL advance_%0d: got seen=%0d wd=%0d/%0d addr0=%0d required wd=%0d addr0=%0d",
                 k, got, wdl, wdr, rom_addr[14:0], k * 4, k);
      end
    end
  endtask

  task automatic test_full_length();
    int n; bit got;
    for (int k = 4; k < SLEN; k++) begin
      wait_write(2 * DIV + 5, n, got);
      checks++;
      if (!got || wdl !== 24'(k * 4)) begin
        errors++; $display("FAIL play_sample_%0d: got seen=%0d wd=%0d required %0d", k, got, wdl, k * 4);
      end
    end
    for (int k = 0; k < 2; k++) begin
      wait_write(2 * DIV + 5, n, got);
      checks++;
      if (!got || wdl !== 24'd0 || busy !== 2'b00 || rom_addr !== 30'd0) begin
        errors++;
        $display("FAIL end_of_sample_%0d: got seen=%0d wd=%h busy=%b addr=%h required wd=0 busy=0 addr=0",
                 k, got, wdl, busy, rom_addr);
      end
    end
  endtask

  task automatic test_saturation();
    int n; bit got;
    logic [23:0] c0 [3];
    logic [23:0] c1 [3];
    logic [23:0] exp_wd [3];
    c0[0] = 24'h400000; c1[0] = 24'h400000; exp_wd[0] = 24'h7FFFFF;
    c0[1] = 24'hC00000; c1[1] = 24'hC00000; exp_wd[1] = 24'h800000;
    c0[2] = 24'h000100; c1[2] = 24'hFFFF00; exp_wd[2] = 24'h000000;
    rom_mode = 1'b1;
    rom_c0 = c0[0]; rom_c1 = c1[0];
    trig = 2'b11;
    step();
    trig = 2'b00;
    for (int k = 0; k < 3; k++) begin
      wait_write(2 * DIV + 5, n, got);
      checks++;
      if (!got || wdl !== exp_wd[k] || wdr !== exp_wd[k]) begin
        errors++; $display("FAIL mix_sat_%0d: got seen=%0d wd=%h/%h required %h", k, got, wdl, wdr, exp_wd[k]);
      end
      if (k < 2) begin
        rom_c0 = c0[k + 1]; rom_c1 = c1[k + 1];
      end
    end
    rom_mode = 1'b0;
  endtask

  task automatic test_retrigger();
    bit found = 1'b0;
    for (int n = 0; n < 20000 && !found; n++) begin
      step();
      if (rom_addr[29:15] === 15'd500) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reach_addr_500: got addr1=%0d required 500 within bound", rom_addr[29:15]);
    end
    repeat (DIV - 1) step();
    trig = 2'b10;
    step();
    trig = 2'b00;
    checks++;
    if (rom_addr[29:15] !== 15'd0 || rom_addr[14:0] !== 15'd501 || busy !== 2'b11) begin
      errors++;
      $display("FAIL retrig_on_tick: got addr1=%0d addr0=%0d busy=%b required addr1=0 addr0=501 busy=11",
               rom_addr[29:15], rom_addr[14:0], busy);
    end
    repeat (DIV - 1) step();
    checks++;
    if (rom_addr[29:15] !== 15'd0) begin
      errors++; $display("FAIL retrig_hold: got addr1=%0d required 0", rom_addr[29:15]);
    end
    step();
    checks++;
    if (rom_addr[29:15] !== 15'd1 || rom_addr[14:0] !== 15'd502) begin
      errors++;
      $display("FAIL retrig_next_tick: got addr1=%0d addr0=%0d required addr1=1 addr0=502",
               rom_addr[29:15], rom_addr[14:0]);
    end
  endtask

  task automatic test_overrun_reset();
    int bad_writes = 0;
    write_ready = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (write !== 1'b0) bad_writes++;
    end
    checks++;
    if (bad_writes != 0 || overrun !== 1'b1 || wdl !== 24'd600) begin
      errors++;
      $display("FAIL stall_overrun: got writes=%0d ovr=%b wd=%0d required writes=0 ovr=1 wd=600",
               bad_writes, overrun, wdl);
    end
    write_ready = 1'b1;
    #1;
    checks++;
    if (write !== 1'b1 || wdl !== 24'd600 || wdr !== 24'd600) begin
      errors++; $display("FAIL resume_write: got w=%b wd=%0d/%0d required w=1 wd=600", write, wdl, wdr);
    end
    step();
    checks++;
    if (write !== 1'b0) begin
      errors++; $display("FAIL single_write: got w=%b required 0", write);
    end
    write_ready = 1'b0;
    step();
    checks++;
    if (wdl !== 24'd604 || overrun !== 1'b1 || write !== 1'b0) begin
      errors++; $display("FAIL next_pending: got wd=%0d ovr=%b w=%b required wd=604 ovr=1 w=0", wdl, overrun, write);
    end
    reset = 1'b1;
    write_ready = 1'b1;
    #1;
    checks++;
    if (write !== 1'b0) begin
      errors++; $display("FAIL write_in_reset: got w=%b required 0", write);
    end
    step();
    checks++;
    if ({write, busy, overrun, rom_addr, wdl} !== '0) begin
      errors++;
      $display("FAIL mid_play_reset: got w=%b busy=%b ovr=%b addr=%h wd=%h required all zero",
               write, busy, overrun, rom_addr, wdl);
    end
    reset = 1'b0;
    bad_writes = 0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (write !== 1'b0) bad_writes++;
    end
    checks++;
    if (bad_writes != 0) begin
      errors++; $display("FAIL pending_dropped: got %0d writes required 0", bad_writes);
    end
  endtask

  initial begin
    reset = 1'b1; trig = 2'b00; write_ready = 1'b1; rom_mode = 1'b0;
    rom_c0 = '0; rom_c1 = '0;
    test_reset();
    test_silence();
    test_voice_advance();
    test_full_length();
    test_saturation();
    test_retrigger();
    test_overrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
